alu_arbiter: RTL and testbench

Registered round-robin arbiter that shares the calculator's single combinational ALU between two requesters, e.g. the user-facing calculator FSM and a background accumulator or self-test engine. Each requester presents an opcode and two operands with a request. The arbiter grants one requester, drives the ALU from registered operands, waits a programmable settle time, captures the result into that requester's result register and pulses done. It sits between the requesters and the ALU instance; the ALU itself is unchanged.

---
 rtl/alu_arbiter_if.sv | 25 ++
 rtl/alu_arbiter.sv | 121 ++++++++++++
 tb/tb_alu_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the ALU arbiter: two request ports, abort, status and
// the per-port grant, done and result returns.
interface alu_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 3
);
    logic             req0, req1;
    logic [OP_W-1:0]  op0, op1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             abort;
    logic             gnt0, gnt1;
    logic             done0, done1;
    logic [WIDTH-1:0] result0, result1;
    logic             busy;

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1, abort,
        input  gnt0, gnt1, done0, done1, result0, result1, busy
    );

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1, abort,
        output gnt0, gnt1, done0, done1, result0, result1, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters:
// grant, registered operands, ALU_LAT settle cycles, per-port result capture.
module alu_arbiter #(
    parameter int WIDTH   = 8,
    parameter int OP_W    = 3,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     rq,
    output logic [OP_W-1:0]  alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result
);
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             done0_q, done0_d, done1_q, done1_d;
    logic [WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             win;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        res0_d  = res0_q;
        res1_d  = res1_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        // On a tie the port that did not win last time goes next
        win     = (rq.req0 && rq.req1) ? ~last_q : rq.req1;
        case (state_q)
            IDLE: begin
                if (rq.req0 || rq.req1) begin
                    op_d    = win ? rq.op1 : rq.op0;
                    a_d     = win ? rq.a1  : rq.a0;
                    b_d     = win ? rq.b1  : rq.b0;
                    last_d  = win;
                    owner_d = win;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    cnt_d   = CNT_W'(ALU_LAT - 1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (rq.abort) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (owner_q) res1_d = alu_result;
                    else         res0_d = alu_result;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            res0_q  <= '0;
            res1_q  <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign rq.gnt0    = gnt0_q;
    assign rq.gnt1    = gnt1_q;
    assign rq.done0   = done0_q;
    assign rq.done1   = done1_q;
    assign rq.result0 = res0_q;
    assign rq.result1 = res1_q;
    assign rq.busy    = (state_q != IDLE);
    assign alu_op     = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: one instance with ALU_LAT=1 (index 0) and
// one with ALU_LAT=4 (index 1), both driven by an add/sub ALU model.
module tb_alu_arbiter;
    logic clk, rst_n;
    logic [1:0]       req0, req1, abort;
    logic [1:0][2:0]  op0, op1;
    logic [1:0][7:0]  a0, b0, a1, b1;
    logic [1:0]       gnt0, gnt1, done0, done1, busy;
    logic [1:0][7:0]  result0, result1, alu_a, alu_b, alu_res;
    logic [1:0][2:0]  alu_op;
    int n_chk, n_fail, cyc;
    logic [7:0] sb_q[4][$];

    alu_arbiter_if #(.WIDTH(8), .OP_W(3)) if_a ();
    alu_arbiter_if #(.WIDTH(8), .OP_W(3)) if_b ();

    alu_arbiter #(.WIDTH(8), .OP_W(3), .ALU_LAT(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .rq(if_a.slave), .alu_op(alu_op[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_result(alu_res[0]));
    alu_arbiter #(.WIDTH(8), .OP_W(3), .ALU_LAT(4)) u_dut_l4 (
        .clk(clk), .rst_n(rst_n), .rq(if_b.slave), .alu_op(alu_op[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_result(alu_res[1]));

    function automatic logic [7:0] alu_f(logic [2:0] op, logic [7:0] a, logic [7:0] b);
        return (op == 3'b001) ? a - b : a + b;
    endfunction

    assign alu_res[0] = alu_f(alu_op[0], alu_a[0], alu_b[0]);
    assign alu_res[1] = alu_f(alu_op[1], alu_a[1], alu_b[1]);

    assign if_a.req0 = req0[0];  assign if_b.req0 = req0[1];
    assign if_a.req1 = req1[0];  assign if_b.req1 = req1[1];
    assign if_a.op0  = op0[0];   assign if_b.op0  = op0[1];
    assign if_a.op1  = op1[0];   assign if_b.op1  = op1[1];
    assign if_a.a0   = a0[0];    assign if_b.a0   = a0[1];
    assign if_a.b0   = b0[0];    assign if_b.b0   = b0[1];
    assign if_a.a1   = a1[0];    assign if_b.a1   = a1[1];
    assign if_a.b1   = b1[0];    assign if_b.b1   = b1[1];
    assign if_a.abort = abort[0]; assign if_b.abort = abort[1];
    assign gnt0[0] = if_a.gnt0;   assign gnt0[1] = if_b.gnt0;
    assign gnt1[0] = if_a.gnt1;   assign gnt1[1] = if_b.gnt1;
    assign done0[0] = if_a.done0; assign done0[1] = if_b.done0;
    assign done1[0] = if_a.done1; assign done1[1] = if_b.done1;
    assign busy[0] = if_a.busy;   assign busy[1] = if_b.busy;
    assign result0[0] = if_a.result0; assign result0[1] = if_b.result0;
    assign result1[0] = if_a.result1; assign result1[1] = if_b.result1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer plus one-hot checks on the pulses
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (gnt0[d] && gnt1[d])   check("gnt_excl", 32'({gnt0[d], gnt1[d]}), 32'h1);
            if (done0[d] && done1[d]) check("done_excl", 32'({done0[d], done1[d]}), 32'h1);
            for (int p = 0; p < 2; p++) begin
                if ((p == 0) ? done0[d] : done1[d]) begin
                    if (sb_q[d*2+p].size() == 0)
                        check("done_unexp", 32'(d*2+p), 32'hFF);
                    else
                        check("sb_res", 32'((p == 0) ? result0[d] : result1[d]),
                              32'(sb_q[d*2+p].pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(int d, int p, logic [2:0] op, logic [7:0] a, logic [7:0] b, bit push);
        if (p == 0) begin op0[d] = op; a0[d] = a; b0[d] = b; req0[d] = 1'b1; end
        else        begin op1[d] = op; a1[d] = a; b1[d] = b; req1[d] = 1'b1; end
        if (push) sb_q[d*2+p].push_back(alu_f(op, a, b));
    endtask

    task automatic wait_gnt(int d, int p, output int lat);
        int  n;
        logic seen;
        n = 0; seen = 1'b0;
        while (!seen && n < 50) begin
            tick();
            n++;
            seen = (p == 0) ? gnt0[d] : gnt1[d];
        end
        if (!seen) check("gnt_tmo", 32'(seen), 32'h1);
        if (p == 0) req0[d] = 1'b0; else req1[d] = 1'b0;
        lat = n;
    endtask

    task automatic wait_idle(int d);
        int n;
        n = 0;
        while (busy[d] && n < 100) begin tick(); n++; end
        if (busy[d]) check("idle_tmo", 32'(busy[d]), 32'h0);
    endtask

    task automatic run_tie(int d, int n_each, int first);
        int g, c0, c1, n, lc, p, lat;
        g = 0; c0 = 0; c1 = 0; n = 0; lc = 0;
        lat = (d == 0) ? 1 : 4;
        for (int i = 0; i < n_each; i++) begin
            sb_q[d*2].push_back(alu_f(op0[d], a0[d], b0[d]));
            sb_q[d*2+1].push_back(alu_f(op1[d], a1[d], b1[d]));
        end
        req0[d] = 1'b1; req1[d] = 1'b1;
        while ((c0 < n_each || c1 < n_each) && n < 300) begin
            tick();
            n++;
            if (gnt0[d] || gnt1[d]) begin
                p = gnt1[d] ? 1 : 0;
                check("tie_order", 32'(p), 32'((g % 2 == 0) ? first : 1 - first));
                if (g > 0) check("tie_gap", 32'(cyc - lc), 32'(lat + 2));
                lc = cyc;
                g++;
                if (gnt0[d]) begin c0++; if (c0 == n_each) req0[d] = 1'b0; end
                if (gnt1[d]) begin c1++; if (c1 == n_each) req1[d] = 1'b0; end
            end
        end
        req0[d] = 1'b0; req1[d] = 1'b0;
        check("tie_count", 32'(g), 32'(2 * n_each));
        wait_idle(d);
    endtask

    task automatic chk_zero(int d, string pfx);
        check({pfx, "_gnt"},  32'({gnt0[d], gnt1[d]}), 32'h0);
        check({pfx, "_done"}, 32'({done0[d], done1[d]}), 32'h0);
        check({pfx, "_busy"}, 32'(busy[d]), 32'h0);
        check({pfx, "_res"},  32'({result0[d], result1[d]}), 32'h0);
        check({pfx, "_alu"},  32'({alu_op[d], alu_a[d], alu_b[d]}), 32'h0);
    endtask

    initial begin
        int lat, gc, dc, bn;
        bit stable;
        n_chk = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0; req0 = '0; req1 = '0; abort = '0;
        op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        tick(); tick();
        chk_zero(0, "rst_l1");
        chk_zero(1, "rst_l4");
        rst_n = 1'b1;
        tick();

        // Single request, ALU_LAT=1
        drive(0, 0, 3'b000, 8'h12, 8'h34, 1'b1);
        wait_gnt(0, 0, lat);
        check("t1_gnt_lat", 32'(lat), 32'h1);
        wait_idle(0);
        check("t1_res0", 32'(result0[0]), 32'h46);
        check("t1_res1", 32'(result1[0]), 32'h0);

        // 8-bit wrap on port 1, port 0 untouched
        drive(0, 1, 3'b000, 8'hFF, 8'h01, 1'b1);
        wait_gnt(0, 1, lat);
        wait_idle(0);
        check("wrap_res1", 32'(result1[0]), 32'h00);
        check("wrap_res0", 32'(result0[0]), 32'h46);

        // Continuous contention, last=1 so port 0 leads
        op0[0] = 3'b000; a0[0] = 8'd5;  b0[0] = 8'd3;
        op1[0] = 3'b000; a1[0] = 8'd10; b1[0] = 8'd1;
        run_tie(0, 2, 0);
        check("tie_res0", 32'(result0[0]), 32'd8);
        check("tie_res1", 32'(result1[0]), 32'd11);

        // ALU_LAT=4 latency, busy length and operand stability
        drive(1, 1, 3'b001, 8'h43, 8'h21, 1'b1);
        wait_gnt(1, 1, lat);
        gc = cyc; dc = -1; bn = busy[1] ? 1 : 0; stable = 1'b1;
        while (busy[1] && bn < 50) begin
            if (alu_a[1] != 8'h43 || alu_b[1] != 8'h21 || alu_op[1] != 3'b001) stable = 1'b0;
            tick();
            if (busy[1]) bn++;
            if (done1[1]) dc = cyc;
        end
        check("t3_done_dist", 32'(dc - gc), 32'd4);
        check("t3_busy_len", 32'(bn), 32'd5);
        check("t3_alu_stable", 32'(stable), 32'h1);
        check("t3_alu_hold", 32'({alu_a[1], alu_b[1]}), 32'h4321);
        check("t3_res1", 32'(result1[1]), 32'h22);

        drive(1, 0, 3'b000, 8'h12, 8'h34, 1'b1);
        wait_gnt(1, 0, lat);
        wait_idle(1);
        check("t4_pre_res0", 32'(result0[1]), 32'h46);

        // Abort in the second EXEC cycle with port 1 pending
        drive(1, 0, 3'b000, 8'h01, 8'h01, 1'b0);
        wait_gnt(1, 0, lat);
        drive(1, 1, 3'b000, 8'h30, 8'h05, 1'b1);
        tick();
        abort[1] = 1'b1;
        tick();
        abort[1] = 1'b0;
        check("t4_idle", 32'(busy[1]), 32'h0);
        wait_gnt(1, 1, lat);
        check("t4_next_gnt_lat", 32'(lat), 32'h1);
        wait_idle(1);
        check("t4_res0_kept", 32'(result0[1]), 32'h46);
        check("t4_res1", 32'(result1[1]), 32'h35);

        // Asynchronous reset while EXEC is in flight
        drive(1, 0, 3'b000, 8'h07, 8'h07, 1'b1);
        wait_gnt(1, 0, lat);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk_zero(1, "t5_arst");
        sb_q[2].delete();
        sb_q[3].delete();
        tick();
        rst_n = 1'b1;
        tick();
        op0[1] = 3'b000; a0[1] = 8'h11; b0[1] = 8'h22;
        op1[1] = 3'b001; a1[1] = 8'h50; b1[1] = 8'h10;
        run_tie(1, 1, 0);
        check("t5_res0", 32'(result0[1]), 32'h33);
        check("t5_res1", 32'(result1[1]), 32'h40);

        tick(); tick();
        for (int i = 0; i < 4; i++) check("sb_empty", 32'(sb_q[i].size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
